// File: rtl/conv_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// conv_pkg : shared widths and sizing helpers for the conv MAC engine
// Revision : 1.0
// ------------------------------------------------------------------
package conv_pkg;

  localparam int DEF_DW = 12;
  localparam int DEF_WW = 8;
  localparam int DEF_OW = 14;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

  function automatic int addr_width(input int n);
    return (n > 1) ? clog2(n) : 1;
  endfunction

  function automatic int acc_width(input int ch, input int k, input int dw, input int ww);
    return dw + ww + clog2(k * k) + clog2(ch);
  endfunction

  function automatic int latency(input int ch, input int k);
    return 3 + clog2(k * k) + clog2(ch);
  endfunction

endpackage
`default_nettype wire

// File: rtl/conv_calc_mc_if.sv
`default_nettype none
// ------------------------------------------------------------------
// conv_calc_mc_if : sample stream, coefficient write port and results
// Revision : 1.0
// ------------------------------------------------------------------
interface conv_calc_mc_if #(
  parameter int CH = 3,
  parameter int K  = 5,
  parameter int DW = conv_pkg::DEF_DW,
  parameter int WW = conv_pkg::DEF_WW,
  parameter int OW = conv_pkg::DEF_OW
);
  localparam int NT = CH * K * K;
  localparam int AW = conv_pkg::addr_width(NT);

  logic                 in_valid;
  logic [NT*DW-1:0]     in_data;
  logic                 w_wr_en;
  logic [AW-1:0]        w_wr_addr;
  logic signed [WW-1:0] w_wr_data;
  logic                 b_wr_en;
  logic signed [OW-1:0] b_wr_data;
  logic                 w_wr_err;
  logic                 out_valid;
  logic signed [OW-1:0] out_data;
  logic                 out_sat;

  modport master (
    output in_valid, in_data, w_wr_en, w_wr_addr, w_wr_data, b_wr_en, b_wr_data,
    input  w_wr_err, out_valid, out_data, out_sat
  );

  modport slave (
    input  in_valid, in_data, w_wr_en, w_wr_addr, w_wr_data, b_wr_en, b_wr_data,
    output w_wr_err, out_valid, out_data, out_sat
  );
endinterface
`default_nettype wire

// File: rtl/conv_adder_tree.sv
`default_nettype none
// ------------------------------------------------------------------
// conv_adder_tree : pipelined signed reduction, one pairing level per clock
// Revision : 1.0
// ------------------------------------------------------------------
module conv_adder_tree
  import conv_pkg::*;
#(
  parameter int N  = 2,
  parameter int IW = 8
) (
  input  logic                          clk,
  input  logic [N*IW-1:0]               in_data,
  output logic signed [IW+clog2(N)-1:0] sum
);
  localparam int L  = clog2(N);
  localparam int SW = IW + L;

  // Element count present at the input of level l.
  function automatic int cnt_at(input int l);
    return (N + (1 << l) - 1) >> l;
  endfunction

  function automatic int clamp(input int j);
    return (j < N) ? j : N - 1;
  endfunction

  logic signed [SW-1:0] ext [N];

  always_comb begin
    for (int i = 0; i < N; i++)
      ext[i] = SW'($signed(in_data[i*IW +: IW]));
  end

  generate
    if (L == 0) begin : g_pass
      assign sum = ext[0];
    end else begin : g_tree
      logic signed [SW-1:0] stg [L][N];
      logic signed [SW-1:0] src [L][N];

      always_comb begin
        for (int l = 0; l < L; l++)
          for (int i = 0; i < N; i++)
            src[l][i] = (l == 0) ? ext[i] : stg[(l == 0) ? 0 : l - 1][i];
      end

      // An odd leftover element is carried forward unchanged.
      always_ff @(posedge clk) begin
        for (int l = 0; l < L; l++) begin
          for (int i = 0; i < N; i++) begin
            if (2 * i + 1 < cnt_at(l))
              stg[l][i] <= src[l][clamp(2 * i)] + src[l][clamp(2 * i + 1)];
            else if (2 * i < cnt_at(l))
              stg[l][i] <= src[l][clamp(2 * i)];
            else
              stg[l][i] <= '0;
          end
        end
      end

      assign sum = stg[L-1][0];
    end
  endgenerate
endmodule
`default_nettype wire

// File: rtl/conv_calc_mc.sv
`default_nettype none
// ------------------------------------------------------------------
// conv_calc_mc : multi-channel KxK convolution MAC with shift/bias/sat/ReLU
// Revision : 1.0
// ------------------------------------------------------------------
module conv_calc_mc
  import conv_pkg::*;
#(
  parameter int CH    = 3,
  parameter int K     = 5,
  parameter int DW    = DEF_DW,
  parameter int WW    = DEF_WW,
  parameter int OW    = DEF_OW,
  parameter int SHIFT = 7,
  parameter int RELU  = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  conv_calc_mc_if.slave bus
);
  localparam int KK   = K * K;
  localparam int NT   = CH * KK;
  localparam int AW   = addr_width(NT);
  localparam int T1   = clog2(KK);
  localparam int PW   = DW + WW;
  localparam int CW   = PW + T1;
  localparam int ACCW = acc_width(CH, K, DW, WW);
  localparam int LAT  = latency(CH, K);
  localparam int RW   = ((ACCW > OW) ? ACCW : OW) + 1;
  localparam logic signed [RW-1:0] MAX_V = {{(RW-OW+1){1'b0}}, {(OW-1){1'b1}}};
  localparam logic signed [RW-1:0] MIN_V = {{(RW-OW+1){1'b1}}, {(OW-1){1'b0}}};

  logic signed [WW-1:0] weight [NT];
  logic signed [OW-1:0] bias;
  logic [LAT-2:0]       vpipe;
  logic                 reject;

  // Coefficients are frozen while any sample is entering or in flight.
  always_comb begin
    reject = bus.in_valid | (|vpipe) |
             (bus.w_wr_en & ({1'b0, bus.w_wr_addr} >= (AW+1)'(NT)));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NT; i++) weight[i] <= '0;
      bias         <= '0;
      bus.w_wr_err <= 1'b0;
    end else begin
      bus.w_wr_err <= (bus.w_wr_en | bus.b_wr_en) & reject;
      if (!reject) begin
        if (bus.w_wr_en) weight[bus.w_wr_addr] <= bus.w_wr_data;
        if (bus.b_wr_en) bias <= bus.b_wr_data;
      end
    end
  end

  logic [NT*DW-1:0]     s0_data;
  logic signed [PW-1:0] mult [NT];
  logic signed [PW-1:0] prod [NT];
  logic [NT*PW-1:0]     prod_flat;

  always_ff @(posedge clk) begin
    if (bus.in_valid) s0_data <= bus.in_data;
    for (int i = 0; i < NT; i++) prod[i] <= mult[i];
  end

  always_comb begin
    for (int i = 0; i < NT; i++) begin
      mult[i] = PW'($signed(s0_data[i*DW +: DW])) * PW'(weight[i]);
      prod_flat[i*PW +: PW] = prod[i];
    end
  end

  logic [CH*CW-1:0]       ch_flat;
  logic signed [ACCW-1:0] acc;

  generate
    for (genvar c = 0; c < CH; c++) begin : g_ch
      conv_adder_tree #(.N(KK), .IW(PW)) u_tap_tree (
        .clk     (clk),
        .in_data (prod_flat[c*KK*PW +: KK*PW]),
        .sum     (ch_flat[c*CW +: CW])
      );
    end
  endgenerate

  conv_adder_tree #(.N(CH), .IW(CW)) u_ch_tree (
    .clk     (clk),
    .in_data (ch_flat),
    .sum     (acc)
  );

  logic signed [ACCW-1:0] shifted;
  logic signed [RW-1:0]   r_full;
  logic signed [OW-1:0]   res;
  logic                   sat_n;

  always_comb begin
    shifted = acc >>> SHIFT;
    r_full  = RW'(shifted) + RW'(bias);
    res     = r_full[OW-1:0];
    sat_n   = 1'b0;
    if (r_full > MAX_V) begin
      res   = MAX_V[OW-1:0];
      sat_n = 1'b1;
    end else if (r_full < MIN_V) begin
      res   = MIN_V[OW-1:0];
      sat_n = 1'b1;
    end
    if (RELU != 0 && r_full < 0) begin
      res   = '0;
      sat_n = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vpipe         <= '0;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_sat   <= 1'b0;
    end else begin
      vpipe         <= {vpipe[LAT-3:0], bus.in_valid};
      bus.out_valid <= vpipe[LAT-2];
      if (vpipe[LAT-2]) begin
        bus.out_data <= res;
        bus.out_sat  <= sat_n;
      end
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_conv_calc_mc.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_conv_calc_mc : randomized bench against an arithmetic reference model
// Revision : 1.0
// ------------------------------------------------------------------
module tb_conv_calc_mc;
  localparam int CH = 3, K = 5, KK = 25, NT = 75, DW = 12, WW = 8, OW = 14;
  localparam int AW = 7, LAT = 10;
  localparam longint DIV = 128, OMAX = 8191, OMIN = -8192;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n = 1'b0, in_valid = 1'b0, w_wr_en = 1'b0, b_wr_en = 1'b0;
  logic [NT*DW-1:0] in_data = '0;
  logic [AW-1:0]    w_wr_addr = '0;
  logic [WW-1:0]    w_wr_data = '0;
  logic [OW-1:0]    b_wr_data = '0;

  conv_calc_mc_if #(.CH(CH), .K(K), .DW(DW), .WW(WW), .OW(OW)) bus ();
  conv_calc_mc_if #(.CH(CH), .K(K), .DW(DW), .WW(WW), .OW(OW)) bus_r ();

  assign bus.in_valid    = in_valid;   assign bus_r.in_valid    = in_valid;
  assign bus.in_data     = in_data;    assign bus_r.in_data     = in_data;
  assign bus.w_wr_en     = w_wr_en;    assign bus_r.w_wr_en     = w_wr_en;
  assign bus.w_wr_addr   = w_wr_addr;  assign bus_r.w_wr_addr   = w_wr_addr;
  assign bus.w_wr_data   = w_wr_data;  assign bus_r.w_wr_data   = w_wr_data;
  assign bus.b_wr_en     = b_wr_en;    assign bus_r.b_wr_en     = b_wr_en;
  assign bus.b_wr_data   = b_wr_data;  assign bus_r.b_wr_data   = b_wr_data;

  conv_calc_mc #(.CH(CH), .K(K), .DW(DW), .WW(WW), .OW(OW), .SHIFT(7), .RELU(0)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus));
  conv_calc_mc #(.CH(CH), .K(K), .DW(DW), .WW(WW), .OW(OW), .SHIFT(7), .RELU(1)) dut_r (
    .clk(clk), .rst_n(rst_n), .bus(bus_r));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0, checks = 0;
  int wm [NT];
  int bm = 0;
  int pix [NT];
  longint exp_q[$], expr_q[$];
  bit     sat_q[$], satr_q[$];
  int     due_q[$];

  // Reference: exact integer dot product, floor division, clip, then ReLU variant.
  function automatic void push_sample();
    longint acc, sh, r, e, er;
    bit s, sr;
    acc = 0;
    for (int i = 0; i < NT; i++) acc += longint'(pix[i]) * longint'(wm[i]);
    if (acc >= 0) sh = acc / DIV;
    else          sh = -((-acc + DIV - 1) / DIV);
    r = sh + longint'(bm);
    e = r; s = 1'b0;
    if (r > OMAX)      begin e = OMAX; s = 1'b1; end
    else if (r < OMIN) begin e = OMIN; s = 1'b1; end
    er = e; sr = s;
    if (r < 0) begin er = 0; sr = 1'b0; end
    exp_q.push_back(e);   sat_q.push_back(s);
    expr_q.push_back(er); satr_q.push_back(sr);
    due_q.push_back(cyc + LAT);
  endfunction

  function automatic void fill(input int mode, input int k, input int cval);
    for (int i = 0; i < NT; i++) begin
      case (mode)
        0:       pix[i] = cval;
        1:       pix[i] = i + k;
        default: pix[i] = int'($urandom_range(0, 4095)) - 2048;
      endcase
    end
  endfunction

  // Drives n samples back to back, optionally injecting a weight write or a reset.
  task automatic stream(input int n, input int mode, input int cval, input int inj_at,
                        input int inj_addr, input int inj_data, input int rst_at);
    bit exp_err, busy, exp_v;
    logic signed [OW-1:0] ed, edr;
    int span;
    exp_err = 1'b0;
    span = (rst_at >= 0) ? rst_at + 18 : n + LAT + 6;
    for (int t = 0; t < span; t++) begin
      @(posedge clk); #1;
      rst_n = 1'b1; w_wr_en = 1'b0; in_valid = 1'b0;
      if (t == rst_at) begin
        rst_n = 1'b0;
        exp_q.delete(); sat_q.delete(); expr_q.delete(); satr_q.delete(); due_q.delete();
        for (int i = 0; i < NT; i++) wm[i] = 0;
        bm = 0;
      end
      if (t < n) begin
        fill(mode, t, cval);
        for (int i = 0; i < NT; i++) in_data[i*DW +: DW] = DW'(pix[i]);
        in_valid = 1'b1;
        push_sample();
      end
      if (t == inj_at) begin
        busy = in_valid;
        foreach (due_q[j]) if (due_q[j] > cyc) busy = 1'b1;
        exp_err = busy || (inj_addr >= NT);
        w_wr_en = 1'b1; w_wr_addr = AW'(inj_addr); w_wr_data = WW'(inj_data);
        if (!exp_err) wm[inj_addr] = inj_data;
      end
      @(negedge clk);
      if (t == inj_at + 1) begin
        checks++;
        if (bus.w_wr_err !== exp_err || bus_r.w_wr_err !== exp_err) begin
          errors++;
          $display("FAIL lock_err: w_wr_err=%0b/%0b expected %0b", bus.w_wr_err, bus_r.w_wr_err, exp_err);
        end
      end
      exp_v = (due_q.size() > 0) && (due_q[0] == cyc);
      checks++;
      if (bus.out_valid !== exp_v || bus_r.out_valid !== exp_v) begin
        errors++;
        $display("FAIL out_valid @%0d: got %0b/%0b expected %0b", cyc, bus.out_valid, bus_r.out_valid, exp_v);
      end
      if (exp_v) begin
        ed = OW'(exp_q[0]); edr = OW'(expr_q[0]);
        checks++;
        if (bus.out_data !== ed || bus.out_sat !== sat_q[0]) begin
          errors++;
          $display("FAIL out_data: got %0d sat %0b expected %0d sat %0b", bus.out_data, bus.out_sat, ed, sat_q[0]);
        end
        checks++;
        if (bus_r.out_data !== edr || bus_r.out_sat !== satr_q[0]) begin
          errors++;
          $display("FAIL relu_data: got %0d sat %0b expected %0d sat %0b", bus_r.out_data, bus_r.out_sat, edr, satr_q[0]);
        end
        void'(exp_q.pop_front()); void'(sat_q.pop_front());
        void'(expr_q.pop_front()); void'(satr_q.pop_front()); void'(due_q.pop_front());
      end
    end
    checks++;
    if (due_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d results never appeared, expected 0 outstanding", due_q.size());
      exp_q.delete(); sat_q.delete(); expr_q.delete(); satr_q.delete(); due_q.delete();
    end
  endtask

  task automatic load(input bit we, input int addr, input int wd, input bit be, input int bd);
    bit exp_err;
    @(posedge clk); #1;
    exp_err = we && (addr >= NT);
    w_wr_en = we; w_wr_addr = AW'(addr); w_wr_data = WW'(wd);
    b_wr_en = be; b_wr_data = OW'(bd);
    if (!exp_err) begin
      if (we) wm[addr] = wd;
      if (be) bm = bd;
    end
    @(posedge clk); #1;
    w_wr_en = 1'b0; b_wr_en = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.w_wr_err !== exp_err || bus_r.w_wr_err !== exp_err) begin
      errors++;
      $display("FAIL wr_err addr %0d: got %0b/%0b expected %0b", addr, bus.w_wr_err, bus_r.w_wr_err, exp_err);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== '0 || bus.out_sat !== 1'b0 || bus.w_wr_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: valid %0b data %0d sat %0b err %0b expected all 0",
               bus.out_valid, bus.out_data, bus.out_sat, bus.w_wr_err);
    end
    checks++;
    if (bus_r.out_valid !== 1'b0 || bus_r.out_data !== '0 || bus_r.out_sat !== 1'b0) begin
      errors++;
      $display("FAIL reset_state_relu: valid %0b data %0d sat %0b expected all 0",
               bus_r.out_valid, bus_r.out_data, bus_r.out_sat);
    end
    stream(1, 0, 1, -1, 0, 0, -1);
  endtask

  task automatic test_weights();
    for (int i = 0; i < NT; i++) load(1'b1, i, 1, 1'b0, 0);
    load(1'b0, 0, 0, 1'b1, 0);
    stream(1, 0, 128, -1, 0, 0, -1);
    load(1'b0, 0, 0, 1'b1, -49);
    stream(1, 0, 128, -1, 0, 0, -1);
  endtask

  task automatic test_saturation();
    for (int i = 0; i < NT; i++) load(1'b1, i, 127, 1'b0, 0);
    load(1'b0, 0, 0, 1'b1, 0);
    stream(1, 0, 2047, -1, 0, 0, -1);
    stream(1, 0, -2048, -1, 0, 0, -1);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < NT; i++) load(1'b1, i, 1, 1'b0, 0);
    stream(20, 1, 0, -1, 0, 0, -1);
  endtask

  task automatic test_write_lock();
    stream(3, 0, 1, 3, 0, 100, -1);
    stream(1, 0, 128, -1, 0, 0, -1);
    load(1'b1, 75, 55, 1'b1, 300);
    stream(1, 0, 128, -1, 0, 0, -1);
    load(1'b1, 0, 5, 1'b0, 0);
    stream(1, 0, 128, -1, 0, 0, -1);
  endtask

  task automatic test_reset_midstream();
    stream(5, 2, 0, -1, 0, 0, 5);
    stream(1, 2, 0, -1, 0, 0, -1);
  endtask

  task automatic test_random();
    for (int i = 0; i < NT; i++) load(1'b1, i, int'($urandom_range(0, 6)) - 3, 1'b0, 0);
    load(1'b0, 0, 0, 1'b1, int'($urandom_range(0, 4000)) - 2000);
    stream(12, 2, 0, -1, 0, 0, -1);
    for (int i = 0; i < NT; i++) load(1'b1, i, int'($urandom_range(0, 255)) - 128, 1'b0, 0);
    stream(8, 2, 0, -1, 0, 0, -1);
  endtask

  initial begin
    test_reset();
    test_weights();
    test_saturation();
    test_back_to_back();
    test_write_lock();
    test_reset_midstream();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
    $fatal(1, "watchdog expired");
  end
endmodule
`default_nettype wire
